// File: rtl/jogo_sequencia.sv
// jogo_sequencia: sequence-memory game. The player must reproduce a stored
// sequence of DEPTH one-hot moves on N_BOTOES buttons.
// Optional per-move timeout: define JOGO_SEQUENCIA_TIMEOUT_EN to enable it.
module jogo_sequencia #(
  parameter int unsigned N_BOTOES = 4,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TIMEOUT  = 5000,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_BOTOES-1:0] chaves,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [N_BOTOES-1:0] wr_data,
  output logic                acertou,
  output logic                errou,
  output logic                pronto,
  output logic [N_BOTOES-1:0] leds,
  output logic [3:0]          db_estado,
  output logic [AW-1:0]       db_contagem,
  output logic [N_BOTOES-1:0] db_memoria,
  output logic [N_BOTOES-1:0] db_jogada,
  output logic                db_igual,
  output logic                db_tem_jogada,
  output logic                db_timeout
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef JOGO_SEQUENCIA_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h3,
    COMPARA     = 4'h4,
    PROXIMO     = 4'h5,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [AW-1:0]       cont_q, cont_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                tecla_q;
  logic                acertou_q, acertou_d;
  logic                errou_q, errou_d;
  logic                pronto_q, pronto_d;
  logic                timeout_q, timeout_d;

  logic [N_BOTOES-1:0] mem_q [DEPTH];
  logic [N_BOTOES-1:0] mem_rd_c;
  logic                tem_jogada_c;
  logic                igual_c;
  logic                em_fim_c;
  logic                wr_ok_c;

  assign mem_rd_c     = mem_q[cont_q];
  assign tem_jogada_c = (|chaves) & ~tecla_q;
  assign igual_c      = (jogada_q == mem_rd_c);
  assign em_fim_c     = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO) ||
                        (estado_q == FIM_TIMEOUT);
  assign wr_ok_c      = wr_en && !reset && (em_fim_c || (estado_q == INICIAL));

  // Sequence memory: writable only while no game is in progress; never reset.
  always_ff @(posedge clock) begin
    if (wr_ok_c) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state, datapath updates and outcome flags (flags follow the current state).
  always_comb begin
    estado_d  = estado_q;
    cont_d    = cont_q;
    jogada_d  = jogada_q;
    timer_d   = '0;
    acertou_d = (estado_q == FIM_ACERTO);
    errou_d   = (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);
    pronto_d  = em_fim_c;
    timeout_d = TIMEOUT_EN && (estado_q == FIM_TIMEOUT);

    unique case (estado_q)
      INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        cont_d   = '0;
        jogada_d = '0;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (TIMEOUT_EN) timer_d = timer_q + TW'(1);
        // A move wins over a timeout expiring in the same cycle.
        if (tem_jogada_c) begin
          estado_d = REGISTRA;
        end else if (TIMEOUT_EN && (timer_q == TW'(TIMEOUT - 1))) begin
          estado_d = FIM_TIMEOUT;
        end
      end
      REGISTRA: begin
        jogada_d = chaves;
        estado_d = COMPARA;
      end
      COMPARA: begin
        if (!igual_c || !$onehot(jogada_q)) begin
          estado_d = FIM_ERRO;
        end else if (cont_q == AW'(DEPTH - 1)) begin
          estado_d = FIM_ACERTO;
        end else begin
          estado_d = PROXIMO;
        end
      end
      PROXIMO: begin
        cont_d   = cont_q + AW'(1);
        estado_d = ESPERA;
      end
      default: estado_d = INICIAL;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= INICIAL;
      cont_q    <= '0;
      jogada_q  <= '0;
      timer_q   <= '0;
      tecla_q   <= 1'b0;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
      pronto_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      jogada_q  <= jogada_d;
      timer_q   <= timer_d;
      tecla_q   <= |chaves;
      acertou_q <= acertou_d;
      errou_q   <= errou_d;
      pronto_q  <= pronto_d;
      timeout_q <= timeout_d;
    end
  end

  assign acertou       = acertou_q;
  assign errou         = errou_q;
  assign pronto        = pronto_q;
  assign leds          = jogada_q;
  assign db_estado     = estado_q;
  assign db_contagem   = cont_q;
  assign db_memoria    = mem_rd_c;
  assign db_jogada     = jogada_q;
  assign db_igual      = igual_c;
  assign db_tem_jogada = tem_jogada_c;
  assign db_timeout    = timeout_q;

endmodule

// File: tb/tb_jogo_sequencia.sv
// Randomized self-checking bench for jogo_sequencia against a game-rule model.
module tb_jogo_sequencia;

  localparam int unsigned NB    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
`ifdef JOGO_SEQUENCIA_TIMEOUT_EN
  localparam int unsigned HOLD  = 12;
`else
  localparam int unsigned HOLD  = 50;
`endif

  logic          clock = 1'b0;
  logic          reset, iniciar, wr_en;
  logic [NB-1:0] chaves, wr_data;
  logic [AW-1:0] wr_addr;
  logic          acertou, errou, pronto, db_igual, db_tem_jogada, db_timeout;
  logic [NB-1:0] leds, db_memoria, db_jogada;
  logic [3:0]    db_estado;
  logic [AW-1:0] db_contagem;

  logic [NB-1:0] mem_m   [DEPTH];
  logic [NB-1:0] moves_m [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  jogo_sequencia #(.N_BOTOES(NB), .DEPTH(DEPTH), .TIMEOUT(20)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
    .db_estado(db_estado), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_jogada(db_jogada), .db_igual(db_igual), .db_tem_jogada(db_tem_jogada),
    .db_timeout(db_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [NB-1:0] rand_onehot();
    logic [NB-1:0] one = NB'(1);
    return one << $urandom_range(NB - 1, 0);
  endfunction

  function automatic logic [NB-1:0] rand_press();
    return NB'($urandom_range(2 ** NB - 1, 1));
  endfunction

  task automatic load_mem();
    for (int a = 0; a < DEPTH; a++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = mem_m[a];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic load_std();
    logic [NB-1:0] one = NB'(1);
    for (int a = 0; a < DEPTH; a++) mem_m[a] = one << (a % 4);
    load_mem();
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    check_eq("start_estado", 32'(db_estado), 32'h2);
  endtask

  // Press and release a button; returns just after the edge that leaves COMPARA.
  task automatic press_step(input logic [NB-1:0] v);
    chaves = v;
    tick();
    tick();
    chaves = '0;
    tick();
  endtask

  // Plays moves_m from ESPERA and checks the outcome predicted by the game rules.
  task automatic play_game(input int gap_max, input bit wr_noise);
    int  exp_pos = DEPTH - 1;
    bit  exp_ok  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (moves_m[i] != mem_m[i] || $countones(moves_m[i]) != 1) begin
        exp_pos = i;
        exp_ok  = 1'b0;
        break;
      end
    end
    start_game();
    for (int k = 0; k <= exp_pos; k++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      if (wr_noise) begin
        wr_en   = 1'b1;
        wr_addr = AW'(k);
        wr_data = ~mem_m[k];
        tick();
        wr_en   = 1'b0;
        check_eq("mem_protegida", 32'(db_memoria), 32'(mem_m[k]));
      end
      press_step(moves_m[k]);
      if (k < exp_pos) begin
        tick();
        check_eq("contagem", 32'(db_contagem), 32'(k + 1));
      end else begin
        check_eq("flag_cedo", 32'({acertou, errou}), 32'h0);
        tick();
        check_eq("acertou", 32'(acertou), 32'(exp_ok));
        check_eq("errou", 32'(errou), 32'(!exp_ok));
        check_eq("pronto", 32'(pronto), 32'h1);
        check_eq("estado_fim", 32'(db_estado), exp_ok ? 32'hA : 32'hE);
        check_eq("contagem_fim", 32'(db_contagem), 32'(exp_pos));
        check_eq("leds", 32'(leds), 32'(moves_m[exp_pos]));
        check_eq("db_memoria", 32'(db_memoria), 32'(mem_m[exp_pos]));
        check_eq("db_igual", 32'(db_igual), 32'(moves_m[exp_pos] == mem_m[exp_pos]));
      end
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; chaves = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick();
    reset = 1'b0;
    check_eq("rst_estado", 32'(db_estado), 32'h0);
    check_eq("rst_flags", 32'({acertou, errou, pronto, db_timeout}), 32'h0);
    check_eq("rst_leds", 32'(leds), 32'h0);

    // Full correct game on the 1,2,4,8 pattern.
    load_std();
    for (int i = 0; i < DEPTH; i++) moves_m[i] = mem_m[i];
    play_game(3, 1'b0);

    // Wrong third move.
    for (int i = 0; i < DEPTH; i++) moves_m[i] = mem_m[i];
    moves_m[2] = 4'b0001;
    play_game(3, 1'b0);

    // Holding a button yields a single move.
    start_game();
    chaves = 4'b0001;
    repeat (HOLD) tick();
    chaves = '0;
    tick();
    check_eq("hold_estado", 32'(db_estado), 32'h2);
    check_eq("hold_contagem", 32'(db_contagem), 32'h1);
    do_reset();

    // Non one-hot press fails even when it matches memory.
    mem_m[0] = 4'b0011;
    load_mem();
    for (int i = 0; i < DEPTH; i++) moves_m[i] = mem_m[i];
    play_game(2, 1'b0);

    // Reset mid-game, then replay with preserved memory.
    load_std();
    start_game();
    for (int k = 0; k < 7; k++) begin
      press_step(mem_m[k]);
      tick();
    end
    check_eq("pre_rst_contagem", 32'(db_contagem), 32'h7);
    chaves = 4'b0100;
    do_reset();
    chaves = '0;
    check_eq("mid_rst_estado", 32'(db_estado), 32'h0);
    check_eq("mid_rst_zero", 32'({acertou, errou, pronto, db_timeout, leds, db_jogada, db_contagem}), 32'h0);
    for (int i = 0; i < DEPTH; i++) moves_m[i] = mem_m[i];
    play_game(2, 1'b1);

    // Idle in ESPERA.
    start_game();
`ifdef JOGO_SEQUENCIA_TIMEOUT_EN
    repeat (25) tick();
    check_eq("to_estado", 32'(db_estado), 32'hD);
    check_eq("to_flags", 32'({errou, pronto, db_timeout, acertou}), 32'hE);
`else
    repeat (1000) tick();
    check_eq("idle_estado", 32'(db_estado), 32'h2);
    check_eq("idle_flags", 32'({pronto, db_timeout}), 32'h0);
`endif
    do_reset();

    // Randomized games.
    for (int g = 0; g < 24; g++) begin
      for (int a = 0; a < DEPTH; a++)
        mem_m[a] = ($urandom_range(7, 0) == 0) ? rand_press() : rand_onehot();
      load_mem();
      for (int a = 0; a < DEPTH; a++)
        moves_m[a] = ($urandom_range(19, 0) == 0) ? rand_press() : mem_m[a];
      play_game(5, 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
